// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: opcode encodings and the
// parameter helpers used to size and sanity-check the pipeline.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int calc_stages(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 0;
    endfunction

    function automatic bit params_legal(input int width, input int chunk);
        return (chunk >= 1) && (width >= 1) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-wide slice of the pipelined adder: adds its chunk, registers the
// carry and the partially-built word, and stalls when downstream is blocked.
module adder_stage #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             next_advance,
    input  logic             prev_valid,
    input  logic             prev_carry,
    input  logic             prev_a_msb,
    input  logic [WIDTH-1:0] prev_acc,
    input  logic [WIDTH-1:0] prev_b,
    output logic             valid,
    output logic             carry,
    output logic             a_msb,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] b_skew
);

    localparam int LO = IDX * CHUNK;

    logic             advance;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] acc_next;

    assign advance   = !valid || next_advance;
    assign chunk_sum = {1'b0, prev_acc[LO +: CHUNK]} + {1'b0, prev_b[LO +: CHUNK]}
                     + {{CHUNK{1'b0}}, prev_carry};

    // acc carries result chunks below LO and untouched operand-A chunks above.
    always_comb begin
        acc_next                 = prev_acc;
        acc_next[LO +: CHUNK]    = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            acc    <= '0;
            b_skew <= '0;
        end else if (advance) begin
            valid <= prev_valid;
            if (prev_valid) begin
                carry  <= chunk_sum[CHUNK];
                a_msb  <= prev_a_msb;
                acc    <= acc_next;
                b_skew <= prev_b;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Elastic pipelined adder/subtractor: WIDTH/CHUNK registered carry-ripple
// stages with valid/ready handshakes on both sides.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
        $error("pipelined_adder: CHUNK must be >= 1 and divide WIDTH exactly");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES:0]   valid_p;
    logic [STAGES:0]   carry_p;
    logic [STAGES:0]   a_msb_p;
    logic [WIDTH-1:0]  acc_p [STAGES+1];
    logic [WIDTH-1:0]  b_p   [STAGES+1];
    logic [STAGES-1:0] next_adv;
    logic              hole;

    // Subtract is a + ~b + !cin, so borrow-in maps onto an inverted carry-in.
    assign b_eff = (sub == OP_SUB) ? ~b : b;
    assign c0    = cin ^ sub;

    assign valid_p[0] = in_valid;
    assign carry_p[0] = c0;
    assign a_msb_p[0] = a[WIDTH-1];
    assign acc_p[0]   = a;
    assign b_p[0]     = b_eff;

    // A stage may move when any stage at or after its successor is empty or
    // the consumer is taking; flattened so no signal feeds back on itself.
    always_comb begin
        hole     = out_ready;
        next_adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            next_adv[k] = hole;
            hole        = hole || !valid_p[k+1];
        end
    end

    assign in_ready = rst_n && hole;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .next_advance (next_adv[k]),
            .prev_valid   (valid_p[k]),
            .prev_carry   (carry_p[k]),
            .prev_a_msb   (a_msb_p[k]),
            .prev_acc     (acc_p[k]),
            .prev_b       (b_p[k]),
            .valid        (valid_p[k+1]),
            .carry        (carry_p[k+1]),
            .a_msb        (a_msb_p[k+1]),
            .acc          (acc_p[k+1]),
            .b_skew       (b_p[k+1])
        );
    end

    assign out_valid = valid_p[STAGES];
    assign sum       = acc_p[STAGES];
    assign cout      = carry_p[STAGES];
    assign ovf       = (a_msb_p[STAGES] == b_p[STAGES][WIDTH-1])
                    && (acc_p[STAGES][WIDTH-1] != a_msb_p[STAGES]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8, CHUNK=4): vector table,
// scoreboard queue, and hand-written stall/reset sequences.
module tb_pipelined_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    int   cyc = 0;
    logic rand_ready = 1'b0;
    vec_t vecs[10];

    pipelined_adder #(.WIDTH(8), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Arithmetic reference written in integer terms, independent of the
    // invert-and-add trick used in hardware.
    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic mcin, input logic msub);
        exp_t e;
        int   ua, ub, sa, sb, r, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            r      = ua + ub + int'(mcin);
            sr     = sa + sb + int'(mcin);
            e.cout = (r > 255);
        end else begin
            r      = ua - ub - int'(mcin);
            sr     = sa - sb - int'(mcin);
            e.cout = (r >= 0);
        end
        e.sum = r[7:0];
        e.ovf = (sr > 127) || (sr < -128);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got sum=%0d cout=%0b ovf=%0b, expected no output",
                         sum, cout, ovf);
            end else begin
                e = exp_q.pop_front();
                popped++;
                if ({sum, cout, ovf} !== e) begin
                    errors++;
                    $display("FAIL result[%0d]: got sum=%0d cout=%0b ovf=%0b, expected sum=%0d cout=%0b ovf=%0b",
                             popped, sum, cout, ovf, e.sum, e.cout, e.ovf);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tcin, input logic tsub, input exp_t e);
        bit accepted;
        accepted = 1'b0;
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) chk("send_accepted", 32'(accepted), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, p0;
        logic [7:0] held;
        bit   stale;

        vecs[0] = '{8'd10,  8'd20,  1'b0, 1'b0, exp_t'{8'd30,  1'b0, 1'b0}};
        vecs[1] = '{8'd255, 8'd1,   1'b0, 1'b0, exp_t'{8'd0,   1'b1, 1'b0}};
        vecs[2] = '{8'd127, 8'd1,   1'b0, 1'b0, exp_t'{8'd128, 1'b0, 1'b1}};
        vecs[3] = '{8'd5,   8'd7,   1'b0, 1'b1, exp_t'{8'd254, 1'b0, 1'b0}};
        vecs[4] = '{8'd128, 8'd1,   1'b0, 1'b1, exp_t'{8'd127, 1'b1, 1'b1}};
        vecs[5] = '{8'd100, 8'd27,  1'b1, 1'b0, exp_t'{8'd128, 1'b0, 1'b1}};
        vecs[6] = '{8'd10,  8'd3,   1'b1, 1'b1, exp_t'{8'd6,   1'b1, 1'b0}};
        vecs[7] = '{8'd128, 8'd255, 1'b0, 1'b0, exp_t'{8'd127, 1'b1, 1'b1}};
        vecs[8] = '{8'd0,   8'd0,   1'b0, 1'b1, exp_t'{8'd0,   1'b1, 1'b0}};
        vecs[9] = '{8'd127, 8'd255, 1'b0, 1'b1, exp_t'{8'd128, 1'b0, 1'b1}};

        // Reset held for three edges
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum",       32'(sum),       32'd0);
        chk("reset_cout",      32'(cout),      32'd0);
        chk("reset_ovf",       32'(ovf),       32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single beat latency
        send(8'd10, 8'd20, 1'b0, 1'b0, exp_t'{8'd30, 1'b0, 1'b0});
        @(negedge clk);
        chk("latency_not_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_sum",   32'(sum),       32'd30);
        drain("drain_single");

        // Vector table streamed back-to-back
        t0 = cyc;
        for (int i = 0; i < 10; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].e);
        chk("throughput_cycles", 32'(cyc - t0), 32'd10);
        drain("drain_table");

        // Six adds with a three-cycle consumer stall
        p0 = popped;
        held = '0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(8'(i * 10 + 1), 8'(i + 3), 1'b0, 1'b0,
                         model(8'(i * 10 + 1), 8'(i + 3), 1'b0, 1'b0));
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = sum;
                chk("stall_full_in_ready", 32'(in_ready),  32'd0);
                chk("stall_out_valid",     32'(out_valid), 32'd1);
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_sum_hold", 32'(sum),      32'(held));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");
        chk("stall_result_count", 32'(popped - p0), 32'd6);

        // Reset pulse with two beats in flight
        out_ready = 1'b0;
        send(8'd50, 8'd60, 1'b0, 1'b0, model(8'd50, 8'd60, 1'b0, 1'b0));
        send(8'd70, 8'd80, 1'b0, 1'b0, model(8'd70, 8'd80, 1'b0, 1'b0));
        rst_n = 1'b0;
        @(negedge clk);
        chk("pulse_in_ready_forced", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("pulse_out_valid", 32'(out_valid), 32'd0);
        chk("pulse_sum",       32'(sum),       32'd0);
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("pulse_no_stale", 32'(stale), 32'd0);
        @(posedge clk);
        #1;
        send(8'd3, 8'd4, 1'b1, 1'b0, exp_t'{8'd8, 1'b0, 1'b0});
        drain("drain_after_pulse");

        // Random operands with a randomly stalling consumer
        p0 = popped;
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb;
            logic       rc, rs;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("drain_random");
        chk("random_result_count", 32'(popped - p0), 32'd24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
